// File: rtl/speaker_i2s_drive_if.sv
// Bundles the tone/volume inputs and the audio DAC pins of speaker_i2s_drive.
// The master side drives vol_data/note_div; the slave side (the driver) drives the audio pins.
interface speaker_i2s_drive_if #(
  parameter int NOTE_DIV_W = 22
);
  logic [31:0]           vol_data;
  logic [NOTE_DIV_W-1:0] note_div;
  logic                  audio_mclk;
  logic                  audio_lrck;
  logic                  audio_sck;
  logic                  audio_sdin;
  logic                  sample_strobe;

  modport master (
    output vol_data, note_div,
    input  audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_strobe
  );

  modport slave (
    input  vol_data, note_div,
    output audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_strobe
  );
endinterface

// File: rtl/speaker_i2s_drive.sv
// Square-wave tone generator serialized onto a 16-bit-per-channel I2S-style DAC link.
// Define I2S_DELAY_EN for Philips timing (sdin delayed one sck period); default is left-justified.
module speaker_i2s_drive #(
  parameter int NOTE_DIV_W = 22,
  parameter int SAMPLE_W   = 16
) (
  input logic                clk,
  input logic                rst,
  speaker_i2s_drive_if.slave bus
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam logic [NOTE_DIV_W-1:0] NOTE_ONE = NOTE_DIV_W'(1);

  logic [8:0]            cnt_q, cnt_d;
  logic [NOTE_DIV_W-1:0] tone_cnt_q, tone_cnt_d;
  logic                  b_clk_q, b_clk_d;
  logic [FRAME_W-1:0]    shift_q, shift_d;
  logic                  sdin_q, sdin_d;
  logic                  mclk_q, mclk_d;
  logic                  sck_q, sck_d;
  logic                  lrck_q, lrck_d;
  logic                  strobe_q, strobe_d;
`ifdef I2S_DELAY_EN
  logic                  dly_q, dly_d;
`endif

  logic                  load_s;
  logic                  shift_en_s;
  logic                  silent_s;
  logic [SAMPLE_W-1:0]   sample_s;

  // Next-state logic for frame divider, tone generator and serializer.
  always_comb begin
    cnt_d      = cnt_q + 9'd1;
    load_s     = (cnt_q == 9'd511);
    shift_en_s = (cnt_q[3:0] == 4'hF) && !load_s;
    silent_s   = (bus.note_div == '0);

    // The >= compare lets a shrinking note_div wrap immediately instead of running away.
    if (silent_s) begin
      tone_cnt_d = '0;
      b_clk_d    = 1'b0;
    end else if (tone_cnt_q >= (bus.note_div - NOTE_ONE)) begin
      tone_cnt_d = '0;
      b_clk_d    = !b_clk_q;
    end else begin
      tone_cnt_d = tone_cnt_q + NOTE_ONE;
      b_clk_d    = b_clk_q;
    end

    if (silent_s) begin
      sample_s = '0;
    end else if (b_clk_q) begin
      sample_s = bus.vol_data[2*SAMPLE_W-1:SAMPLE_W];
    end else begin
      sample_s = bus.vol_data[SAMPLE_W-1:0];
    end

    if (load_s) begin
      shift_d = {sample_s, sample_s};
    end else if (shift_en_s) begin
      shift_d = {shift_q[FRAME_W-2:0], 1'b0};
    end else begin
      shift_d = shift_q;
    end

`ifdef I2S_DELAY_EN
    // One extra stage pushes every bit a full sck period later.
    if (load_s || shift_en_s) begin
      dly_d  = shift_d[FRAME_W-1];
      sdin_d = dly_q;
    end else begin
      dly_d  = dly_q;
      sdin_d = sdin_q;
    end
`else
    if (load_s || shift_en_s) begin
      sdin_d = shift_d[FRAME_W-1];
    end else begin
      sdin_d = sdin_q;
    end
`endif

    // Clock outputs are registered from cnt_d so they line up with cnt_q.
    mclk_d   = cnt_d[1];
    sck_d    = cnt_d[3];
    lrck_d   = cnt_d[8];
    strobe_d = (cnt_d == 9'd511);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 9'd0;
      tone_cnt_q <= '0;
      b_clk_q    <= 1'b0;
      shift_q    <= '0;
      sdin_q     <= 1'b0;
      mclk_q     <= 1'b0;
      sck_q      <= 1'b0;
      lrck_q     <= 1'b0;
      strobe_q   <= 1'b0;
`ifdef I2S_DELAY_EN
      dly_q      <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      tone_cnt_q <= tone_cnt_d;
      b_clk_q    <= b_clk_d;
      shift_q    <= shift_d;
      sdin_q     <= sdin_d;
      mclk_q     <= mclk_d;
      sck_q      <= sck_d;
      lrck_q     <= lrck_d;
      strobe_q   <= strobe_d;
`ifdef I2S_DELAY_EN
      dly_q      <= dly_d;
`endif
    end
  end

  assign bus.audio_mclk    = mclk_q;
  assign bus.audio_sck     = sck_q;
  assign bus.audio_lrck    = lrck_q;
  assign bus.audio_sdin    = sdin_q;
  assign bus.sample_strobe = strobe_q;

endmodule
